// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module      : period_meter
// Description : Measures the period of sig_in, counted in clk cycles between
//               consecutive rising edges, and the number of high cycles within
//               that period. Each result is offered on a valid/ready handshake.
//               If a new result arrives while an older one is still unaccepted,
//               the new result is dropped and the sticky overrun flag is set.
// Ports       : clk         - single clock, rising edge
//               rst_n       - synchronous active-low reset
//               sig_in      - measured signal, already synchronous to clk
//               enable      - measurement enable
//               period_out  - clk cycles between two sig_in rising edges
//               high_out    - clk cycles sig_in was high within that period
//               sat_out     - period counter saturated for this result
//               meas_valid  - a result is held on the outputs
//               meas_ready  - consumer accepts the held result
//               overrun     - sticky; a result was dropped (clears on reset)
// Revision    : 1.0 - initial release
// ============================================================================
module period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             sat_out,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic             sig_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic             sat_q;

  logic             rise;
  logic             cnt_at_max;
  logic             hcnt_at_max;
  logic             capture;
  logic             accept;

  assign rise        = sig_in & ~sig_q;
  assign cnt_at_max  = (cnt_q == CNT_MAX);
  assign hcnt_at_max = (hcnt_q == CNT_MAX);
  // A rise only closes a period when the block is still enabled; a rise on
  // the same edge that enable drops belongs to the discarded partial period.
  assign capture     = (state_q == MEAS) && enable && rise;
  assign accept      = meas_valid && meas_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sig_q      <= 1'b0;
      cnt_q      <= CNT_ZERO;
      hcnt_q     <= CNT_ZERO;
      sat_q      <= 1'b0;
      period_out <= CNT_ZERO;
      high_out   <= CNT_ZERO;
      sat_out    <= 1'b0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sig_q <= sig_in;

      // Measurement state machine
      case (state_q)
        IDLE: begin
          cnt_q  <= CNT_ZERO;
          hcnt_q <= CNT_ZERO;
          sat_q  <= 1'b0;
          if (enable) begin
            state_q <= ARM;
          end
        end

        ARM: begin
          if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            hcnt_q  <= CNT_ZERO;
            sat_q   <= 1'b0;
          end else if (rise) begin
            // The rise cycle itself is the first cycle of the period and is high.
            state_q <= MEAS;
            cnt_q   <= CNT_ONE;
            hcnt_q  <= CNT_ONE;
            sat_q   <= 1'b0;
          end
        end

        MEAS: begin
          if (!enable) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            hcnt_q  <= CNT_ZERO;
            sat_q   <= 1'b0;
          end else if (rise) begin
            cnt_q  <= CNT_ONE;
            hcnt_q <= CNT_ONE;
            sat_q  <= 1'b0;
          end else begin
            if (!cnt_at_max) begin
              cnt_q <= cnt_q + CNT_ONE;
            end else begin
              sat_q <= 1'b1;
            end
            if (sig_in && !hcnt_at_max) begin
              hcnt_q <= hcnt_q + CNT_ONE;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase

      // Result holding register: a capture loads when the slot is empty or
      // is being emptied on this very edge; otherwise the capture is lost.
      if (capture && (!meas_valid || meas_ready)) begin
        period_out <= cnt_q;
        high_out   <= hcnt_q;
        sat_out    <= sat_q;
        meas_valid <= 1'b1;
      end else if (accept) begin
        meas_valid <= 1'b0;
      end

      if (capture && meas_valid && !meas_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the period and high-time counters and results.
REQ-002 clk  input  1  single clock; all logic samples on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 sig_in  input  1  measured signal, e.g. frequency_divider divider_out, already synchronous to clk.
REQ-005 enable  input  1  measurement enable.
REQ-006 period_out  output  CNT_W  clk cycles between two consecutive sig_in rising edges.
REQ-007 high_out  output  CNT_W  clk cycles sig_in was 1 within that period.
REQ-008 sat_out  output  1  the current result saturated.
REQ-009 meas_valid  output  1  a result is held on period_out, high_out and sat_out.
REQ-010 meas_ready  input  1  consumer accepts the result.
REQ-011 overrun  output  1  sticky flag; a result was dropped under backpressure.

Function
REQ-012 A registered copy sig_q SHALL hold sig_in from the previous cycle; rise = sig_in & ~sig_q (combinational).
REQ-013 The FSM SHALL have the states IDLE, ARM and MEAS.
REQ-014 IDLE: the FSM SHALL move to ARM when enable=1; the counters SHALL be held at 0.
REQ-015 ARM: on rise, the FSM SHALL move to MEAS with cnt<=1 and hcnt<=1; no result SHALL be produced.
REQ-016 MEAS, no rise: cnt<=cnt+1 and hcnt<=hcnt+sig_in, both saturating at 2^CNT_W-1.
REQ-017 MEAS, no rise: a sat register SHALL be set if cnt is already at 2^CNT_W-1.
REQ-018 MEAS, on rise: the block SHALL capture period=cnt, high=hcnt and sat, then restart with cnt<=1, hcnt<=1, sat<=0.
REQ-019 Rises N cycles apart SHALL yield period_out=N, and high_out SHALL equal the number of high cycles in that window.
REQ-020 A capture SHALL load the output registers and set meas_valid on the same edge, so the result is visible on the cycle after the rise.
REQ-021 meas_valid SHALL stay 1, with the outputs stable, until a cycle with meas_valid=1 and meas_ready=1; it SHALL clear on that edge.
REQ-022 Capture while meas_valid=1 and meas_ready=0: the new result SHALL be dropped, the old one kept, and overrun set to 1.
REQ-023 Capture in the same cycle as an accepting handshake: the new result SHALL be loaded, meas_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-024 overrun SHALL clear only on reset.
REQ-025 enable=0 in ARM or MEAS: the FSM SHALL return to IDLE on the next edge, clear cnt, hcnt and sat, and discard the partial period.
REQ-026 A pending result SHALL be unaffected by enable and remain until handshake.
REQ-027 Re-enabling SHALL always pass through ARM; the first rise after enable SHALL never produce a result.
REQ-028 A rise while in IDLE SHALL be ignored.

Reset
REQ-029 When rst_n=0 at a clk edge: FSM<=IDLE; sig_q, cnt, hcnt, sat <=0; period_out, high_out, sat_out, meas_valid, overrun <=0.
REQ-030 Reset mid-measurement or with a result pending SHALL discard everything.
REQ-031 The first valid result after reset SHALL require enable=1 and two rises after release.
REQ-032 Reset is synchronous only; rst_n SHALL have no effect between clk edges.

Verification
REQ-033 Scenario 1: enable=1, meas_ready=1, sig_in a 1-cycle pulse every 884 cycles -> from the second pulse on, each result is period_out=884, high_out=1, sat_out=0.
REQ-034 Scenario 2: square wave, 10 cycles high / 6 low, meas_ready=1 -> period_out=16, high_out=10, meas_valid one cycle per period.
REQ-035 Scenario 3: pulses every 20 cycles, meas_ready=0 for 50 cycles -> first result (20) held, overrun=1 after the next capture; on meas_ready=1, meas_valid clears or reloads per REQ-023.
REQ-036 Scenario 4: CNT_W=16, one rise, then sig_in=0 for 70000 cycles, then a rise -> period_out=16'hFFFF, sat_out=1, high_out=1.
REQ-037 Scenario 5: rst_n=0 for one cycle mid-period with meas_valid=1 -> all outputs 0 next cycle; no result until two rises after release.
REQ-038 Scenario 6: enable dropped for 3 cycles mid-period with a result pending -> pending result kept; the next rise after re-enable gives no result; the following rise gives the correct period.
